// File: rtl/storm_dump_ram_if.sv
// Dump-stream bundle between storm_dump_ram (slave) and the debug/trace consumer (master).
// Carries the dump request, the captured address range and the valid/ready word stream.
interface storm_dump_ram_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) ();
  logic              iDumpReq;
  logic [ADDR_W-1:0] iDumpStart;
  logic [ADDR_W-1:0] iDumpEnd;
  logic              iDumpReady;
  logic              oDumpBusy;
  logic              oDumpValid;
  logic [ADDR_W-1:0] oDumpAddr;
  logic [DATA_W-1:0] oDumpData;
  logic              oDumpDone;

  modport master (
    output iDumpReq, iDumpStart, iDumpEnd, iDumpReady,
    input  oDumpBusy, oDumpValid, oDumpAddr, oDumpData, oDumpDone
  );

  modport slave (
    input  iDumpReq, iDumpStart, iDumpEnd, iDumpReady,
    output oDumpBusy, oDumpValid, oDumpAddr, oDumpData, oDumpDone
  );
endinterface

// File: rtl/storm_dump_ram.sv
// STORM data RAM: single core read/write port plus an independent dump engine
// that streams an address range (with wrap-around) over a valid/ready handshake.
module storm_dump_ram #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter bit REG_OUT = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic              iWE,
  input  logic [DATA_W-1:0] iData,
  output logic [DATA_W-1:0] oData,
  storm_dump_ram_if.slave   dump
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] core_rd;

  // NOTE: the array has no reset so it maps onto a RAM macro; contents survive Reset.
  always_ff @(posedge Clk) begin
    if (iWE && in_range(iAddr)) begin
      mem_q[iAddr] <= iData;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= iAddr;
    end
  end

  // Reading through the registered address after the write edge gives write-first.
  always_comb begin
    core_rd = '0;
    if (in_range(addr_q)) begin
      core_rd = mem_q[addr_q];
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // The array updates on the same edge this register loads, so forward the write.
    always_comb begin
      rdata_d = core_rd;
      if (iWE && in_range(iAddr) && (iAddr == addr_q)) begin
        rdata_d = iData;
      end
    end

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign oData = rdata_q;
  end else begin : g_comb_out
    assign oData = core_rd;
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [ADDR_W-1:0] dend_q, dend_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

  // NOTE: every next-state signal takes its hold value first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    daddr_d     = daddr_q;
    dend_d      = dend_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (dump.iDumpReq) begin
          if (in_range(dump.iDumpStart) && in_range(dump.iDumpEnd)) begin
            daddr_d = dump.iDumpStart;
            dend_d  = dump.iDumpEnd;
            busy_d  = 1'b1;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
          end
        end
      end

      S_FETCH: begin
        // The array is written with <=, so this sample is the pre-write value.
        dump_data_d = mem_q[daddr_q];
        dump_addr_d = daddr_q;
        valid_d     = 1'b1;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (dump.iDumpReady) begin
          valid_d = 1'b0;
          if (daddr_q == dend_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            daddr_d = (daddr_q == LAST_ADDR) ? '0 : daddr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      daddr_q     <= '0;
      dend_q      <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      daddr_q     <= daddr_d;
      dend_q      <= dend_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  assign dump.oDumpBusy  = busy_q;
  assign dump.oDumpValid = valid_q;
  assign dump.oDumpDone  = done_q;
  assign dump.oDumpAddr  = dump_addr_q;
  assign dump.oDumpData  = dump_data_q;

endmodule

// File: tb/tb_storm_dump_ram.sv
// Directed bench for storm_dump_ram (DEPTH=1000, REG_OUT=0): core port, range,
// wrap, backpressure, collision, reset-abort and back-to-back dumps.
module tb_storm_dump_ram;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  iAddr;
  logic        iWE;
  logic [15:0] iData;
  logic [15:0] oData;

  storm_dump_ram_if #(.ADDR_W(10), .DATA_W(16)) dif ();

  storm_dump_ram #(
    .DATA_W (16),
    .ADDR_W (10),
    .DEPTH  (1000),
    .REG_OUT(1'b0)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .iAddr(iAddr),
    .iWE  (iWE),
    .iData(iData),
    .oData(oData),
    .dump (dif)
  );

  always #5 Clk = ~Clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int          got_n;
  int          done_edge;
  int          first_valid_edge;
  int          hold_cycles;
  bit          stable_ok;
  logic [9:0]  got_addr [16];
  logic [15:0] got_data [16];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic core_write(input logic [9:0] a, input logic [15:0] d);
    iAddr = a;
    iData = d;
    iWE   = 1'b1;
    tick();
    iWE   = 1'b0;
  endtask

  // Runs one dump; the word with index stall_word is held off for stall_cycles cycles.
  task automatic run_dump(input logic [9:0] s, input logic [9:0] e,
                          input int stall_word, input int stall_cycles);
    int stall_cnt = 0;
    bit prev_valid = 1'b0;
    got_n = 0; done_edge = 0; first_valid_edge = 0; hold_cycles = 0; stable_ok = 1'b1;
    dif.iDumpStart = s;
    dif.iDumpEnd   = e;
    dif.iDumpReq   = 1'b1;
    dif.iDumpReady = 1'b1;
    for (int k = 1; k <= 100 && done_edge == 0; k++) begin
      tick();
      dif.iDumpReq = 1'b0;
      if (dif.oDumpDone) done_edge = k;
      if (dif.oDumpValid) begin
        if (!prev_valid) begin
          if (first_valid_edge == 0) first_valid_edge = k;
          if (got_n < 16) begin
            got_addr[got_n] = dif.oDumpAddr;
            got_data[got_n] = dif.oDumpData;
          end
          got_n++;
        end else if (got_n <= 16) begin
          if (dif.oDumpAddr !== got_addr[got_n-1] || dif.oDumpData !== got_data[got_n-1])
            stable_ok = 1'b0;
        end
        if (got_n - 1 == stall_word) hold_cycles++;
        if (got_n - 1 == stall_word && stall_cnt < stall_cycles) begin
          dif.iDumpReady = 1'b0;
          stall_cnt++;
        end else begin
          dif.iDumpReady = 1'b1;
        end
      end else begin
        dif.iDumpReady = 1'b1;
      end
      prev_valid = dif.oDumpValid;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (dif.oDumpBusy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", dif.oDumpBusy);
    else pass_cnt++;
    total_cnt++;
    if (dif.oDumpValid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dif.oDumpValid);
    else pass_cnt++;
    total_cnt++;
    if (dif.oDumpDone !== 1'b0) $display("FAIL reset_done: got %b expected 0", dif.oDumpDone);
    else pass_cnt++;
    total_cnt++;
    if (dif.oDumpAddr !== 10'h000 || dif.oDumpData !== 16'h0000)
      $display("FAIL reset_dump_bus: got %h/%h expected 000/0000", dif.oDumpAddr, dif.oDumpData);
    else pass_cnt++;
    Reset = 1'b1;
    tick();
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) core_write(10'(i), 16'(i) ^ 16'hA5A5);
    core_write(10'd998, 16'd998 ^ 16'hA5A5);
    core_write(10'd999, 16'd999 ^ 16'hA5A5);
  endtask

  task automatic test_write_read();
    core_write(10'h005, 16'h1234);
    total_cnt++;
    if (oData !== 16'h1234) $display("FAIL write_first: got %h expected 1234", oData);
    else pass_cnt++;
    core_write(10'h3E8, 16'hDEAD);
    total_cnt++;
    if (oData !== 16'h0000) $display("FAIL oor_write_read: got %h expected 0000", oData);
    else pass_cnt++;
    iAddr = 10'h3FF;
    tick();
    total_cnt++;
    if (oData !== 16'h0000) $display("FAIL oor_read_3ff: got %h expected 0000", oData);
    else pass_cnt++;
    iAddr = 10'h007;
    #2;
    total_cnt++;
    if (oData !== 16'h0000) $display("FAIL read_latency: got %h expected 0000", oData);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (oData !== 16'hA5A2) $display("FAIL read_007: got %h expected a5a2", oData);
    else pass_cnt++;
    iAddr = 10'h005;
    tick();
    total_cnt++;
    if (oData !== 16'h1234) $display("FAIL read_005: got %h expected 1234", oData);
    else pass_cnt++;
  endtask

  task automatic test_range_dump();
    logic [15:0] exp_d [4];
    exp_d[0] = 16'hA5B5; exp_d[1] = 16'hA5B4; exp_d[2] = 16'hA5B7; exp_d[3] = 16'hA5B6;
    run_dump(10'h010, 10'h013, -1, 0);
    total_cnt++;
    if (got_n !== 4) $display("FAIL range_count: got %0d expected 4", got_n);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got_addr[i] !== 10'(16 + i) || got_data[i] !== exp_d[i])
        $display("FAIL range_word%0d: got %h/%h expected %h/%h", i, got_addr[i], got_data[i],
                 10'(16 + i), exp_d[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (first_valid_edge !== 2) $display("FAIL range_first_valid: got %0d expected 2", first_valid_edge);
    else pass_cnt++;
    total_cnt++;
    if (done_edge !== 9) $display("FAIL range_done_cycle: got %0d expected 9", done_edge);
    else pass_cnt++;
    total_cnt++;
    if (dif.oDumpBusy !== 1'b0) $display("FAIL range_busy_at_done: got %b expected 0", dif.oDumpBusy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dif.oDumpDone !== 1'b0) $display("FAIL range_done_width: got %b expected 0", dif.oDumpDone);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [9:0]  exp_a [4];
    logic [15:0] exp_d [4];
    exp_a[0] = 10'h3E6; exp_a[1] = 10'h3E7; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    exp_d[0] = 16'hA643; exp_d[1] = 16'hA642; exp_d[2] = 16'hA5A5; exp_d[3] = 16'hA5A4;
    run_dump(10'h3E6, 10'h001, -1, 0);
    total_cnt++;
    if (got_n !== 4) $display("FAIL wrap_count: got %0d expected 4", got_n);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got_addr[i] !== exp_a[i] || got_data[i] !== exp_d[i])
        $display("FAIL wrap_word%0d: got %h/%h expected %h/%h", i, got_addr[i], got_data[i],
                 exp_a[i], exp_d[i]);
      else pass_cnt++;
    end
    run_dump(10'h012, 10'h012, -1, 0);
    total_cnt++;
    if (got_n !== 1 || got_data[0] !== 16'hA5B7 || done_edge !== 3)
      $display("FAIL single_word: got n=%0d data=%h done=%0d expected n=1 data=a5b7 done=3",
               got_n, got_data[0], done_edge);
    else pass_cnt++;
  endtask

  task automatic test_oor_dump();
    dif.iDumpStart = 10'h3F0;
    dif.iDumpEnd   = 10'h3F1;
    dif.iDumpReq   = 1'b1;
    tick();
    dif.iDumpReq   = 1'b0;
    total_cnt++;
    if (dif.oDumpDone !== 1'b1 || dif.oDumpBusy !== 1'b0)
      $display("FAIL oor_dump_done: got done=%b busy=%b expected done=1 busy=0",
               dif.oDumpDone, dif.oDumpBusy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dif.oDumpDone !== 1'b0 || dif.oDumpValid !== 1'b0)
      $display("FAIL oor_dump_idle: got done=%b valid=%b expected 0/0", dif.oDumpDone, dif.oDumpValid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    run_dump(10'h010, 10'h013, 1, 5);
    total_cnt++;
    if (got_n !== 4 || got_addr[1] !== 10'h011 || got_data[1] !== 16'hA5B4 || got_data[2] !== 16'hA5B7)
      $display("FAIL bp_words: got n=%0d w1=%h/%h w2=%h expected n=4 w1=011/a5b4 w2=a5b7",
               got_n, got_addr[1], got_data[1], got_data[2]);
    else pass_cnt++;
    total_cnt++;
    if (stable_ok !== 1'b1) $display("FAIL bp_stable: got %b expected 1", stable_ok);
    else pass_cnt++;
    total_cnt++;
    if (hold_cycles !== 6) $display("FAIL bp_hold_cycles: got %0d expected 6", hold_cycles);
    else pass_cnt++;
    total_cnt++;
    if (done_edge !== 14) $display("FAIL bp_done_cycle: got %0d expected 14", done_edge);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    dif.iDumpStart = 10'h020;
    dif.iDumpEnd   = 10'h020;
    dif.iDumpReady = 1'b1;
    dif.iDumpReq   = 1'b1;
    tick();
    dif.iDumpReq = 1'b0;
    iAddr = 10'h020;
    iData = 16'hBEEF;
    iWE   = 1'b1;
    tick();
    iWE   = 1'b0;
    total_cnt++;
    if (dif.oDumpValid !== 1'b1 || dif.oDumpData !== 16'hA585)
      $display("FAIL collision_dump_old: got valid=%b data=%h expected 1/a585",
               dif.oDumpValid, dif.oDumpData);
    else pass_cnt++;
    total_cnt++;
    if (oData !== 16'hBEEF) $display("FAIL collision_core_new: got %h expected beef", oData);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dif.oDumpDone !== 1'b1) $display("FAIL collision_done: got %b expected 1", dif.oDumpDone);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_dump();
    int  n = 0;
    bit  prev = 1'b0;
    bit  done_seen = 1'b0;
    dif.iDumpStart = 10'h028;
    dif.iDumpEnd   = 10'h02F;
    dif.iDumpReady = 1'b1;
    dif.iDumpReq   = 1'b1;
    for (int k = 0; k < 40 && n < 2; k++) begin
      tick();
      dif.iDumpReq = 1'b0;
      if (dif.oDumpDone) done_seen = 1'b1;
      if (dif.oDumpValid && !prev) n++;
      prev = dif.oDumpValid;
    end
    dif.iDumpReady = 1'b0;
    total_cnt++;
    if (n !== 2 || dif.oDumpAddr !== 10'h029)
      $display("FAIL rst_mid_reach_word2: got n=%0d addr=%h expected 2/029", n, dif.oDumpAddr);
    else pass_cnt++;
    #2;
    Reset = 1'b0;
    #1;
    total_cnt++;
    if (dif.oDumpValid !== 1'b0 || dif.oDumpBusy !== 1'b0 || dif.oDumpAddr !== 10'h000 ||
        dif.oDumpData !== 16'h0000)
      $display("FAIL rst_mid_async_clear: got v=%b b=%b a=%h d=%h expected all 0",
               dif.oDumpValid, dif.oDumpBusy, dif.oDumpAddr, dif.oDumpData);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (dif.oDumpDone) done_seen = 1'b1;
    end
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (dif.oDumpDone) done_seen = 1'b1;
    end
    total_cnt++;
    if (done_seen !== 1'b0) $display("FAIL rst_mid_no_done: got %b expected 0", done_seen);
    else pass_cnt++;
    iAddr = 10'h029;
    tick();
    total_cnt++;
    if (oData !== 16'hA58C) $display("FAIL rst_mid_mem_kept: got %h expected a58c", oData);
    else pass_cnt++;
    run_dump(10'h028, 10'h029, -1, 0);
    total_cnt++;
    if (got_n !== 2 || got_data[0] !== 16'hA58D || got_data[1] !== 16'hA58C || done_edge !== 5)
      $display("FAIL rst_mid_fresh_dump: got n=%0d d0=%h d1=%h done=%0d expected 2/a58d/a58c/5",
               got_n, got_data[0], got_data[1], done_edge);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    dif.iDumpStart = 10'h005;
    dif.iDumpEnd   = 10'h005;
    dif.iDumpReady = 1'b1;
    dif.iDumpReq   = 1'b1;
    tick();
    tick();
    tick();
    total_cnt++;
    if (dif.oDumpDone !== 1'b1 || dif.oDumpBusy !== 1'b0)
      $display("FAIL b2b_first_done: got done=%b busy=%b expected 1/0", dif.oDumpDone, dif.oDumpBusy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dif.oDumpDone !== 1'b0 || dif.oDumpBusy !== 1'b1)
      $display("FAIL b2b_restart: got done=%b busy=%b expected 0/1", dif.oDumpDone, dif.oDumpBusy);
    else pass_cnt++;
    dif.iDumpReq = 1'b0;
    tick();
    total_cnt++;
    if (dif.oDumpValid !== 1'b1 || dif.oDumpData !== 16'h1234)
      $display("FAIL b2b_second_word: got valid=%b data=%h expected 1/1234", dif.oDumpValid, dif.oDumpData);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dif.oDumpDone !== 1'b1) $display("FAIL b2b_second_done: got %b expected 1", dif.oDumpDone);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    Reset          = 1'b0;
    iAddr          = '0;
    iWE            = 1'b0;
    iData          = '0;
    dif.iDumpReq   = 1'b0;
    dif.iDumpStart = '0;
    dif.iDumpEnd   = '0;
    dif.iDumpReady = 1'b0;
    test_reset();
    preload();
    test_write_read();
    test_range_dump();
    test_wrap();
    test_oor_dump();
    test_backpressure();
    test_collision();
    test_reset_mid_dump();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
